// File: rtl/bus_controller_pkg.sv
// Shared definitions for the Z80-style bus controller.
//   wait_state_t : wait FSM states (IDLE / COUNT / HOLD)
//   region_t     : decoded access region used to select wait clocks
//   MAP_*        : offsets of the mapper registers from MAP_PORT
package bus_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } wait_state_t;

    typedef enum logic [1:0] {
        RGN_ROM = 2'd0,
        RGN_RAM = 2'd1,
        RGN_IO  = 2'd2,
        RGN_MAP = 2'd3
    } region_t;

    localparam logic [2:0] MAP_PAGE0  = 3'd0;
    localparam logic [2:0] MAP_PAGE1  = 3'd1;
    localparam logic [2:0] MAP_PAGE2  = 3'd2;
    localparam logic [2:0] MAP_PAGE3  = 3'd3;
    localparam logic [2:0] MAP_ROMCTL = 3'd4;

    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/bus_controller_wait_gen.sv
// Wait-state generator: counts region wait clocks for each bus cycle.
//   clk, n_reset : clock, asynchronous active-low reset
//   i_access     : a qualified mem or io access is present
//   i_idle       : all bus strobes are inactive
//   i_wait       : wait clocks for the current access (loaded in IDLE)
//   o_wait_n     : registered wait request, low exactly while counting
module bus_wait_gen
    import bus_controller_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              i_access,
    input  logic              i_idle,
    input  logic [WAIT_W-1:0] i_wait,
    output logic              o_wait_n
);

    wait_state_t       r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_wait_n;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wait_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_access) begin
                        r_cnt <= i_wait;
                        if (i_wait != '0) begin
                            r_state  <= ST_COUNT;
                            r_wait_n <= 1'b0;
                        end else begin
                            r_state  <= ST_HOLD;
                        end
                    end
                end
                ST_COUNT: begin
                    if (i_idle) begin
                        // CPU abandoned the cycle: release wait right away
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_wait_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == WAIT_W'(1)) begin
                            r_state  <= ST_HOLD;
                            r_wait_n <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_idle) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_wait_n <= 1'b1;
                end
            endcase
        end
    end

    assign o_wait_n = r_wait_n;

endmodule

// File: rtl/bus_controller.sv
// Bus controller: address decode, 4-page SRAM mapper, ROM overlay,
// I/O chip selects, CPU read-data mux and per-region wait states.
//   clk, n_reset                  : clock, asynchronous active-low reset
//   cpu_addr/cpu_dout/cpu_din     : CPU address, write data, read data
//   n_mreq/n_iorq/n_rd/n_wr       : Z80 bus strobes
//   wait_n                        : CPU wait request (active-low)
//   rom_data                      : ROM read data
//   sram_din/sram_addr/n_sram_*   : SRAM data, physical address, controls
//   n_io_cs/io_rd_data            : I/O channel selects and read data
module bus_controller
    import bus_controller_pkg::*;
#(
    parameter int unsigned NUM_IO   = 4,
    parameter int unsigned PHYS_AW  = 18,
    parameter int unsigned ROM_AW   = 13,
    parameter logic [7:0]  IO_BASE  = 8'h80,
    parameter int unsigned IO_SPAN  = 3,
    parameter logic [7:0]  MAP_PORT = 8'hF8,
    parameter int unsigned WAIT_ROM = 0,
    parameter int unsigned WAIT_RAM = 1,
    parameter int unsigned WAIT_IO  = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [15:0]         cpu_addr,
    input  logic [7:0]          cpu_dout,
    input  logic                n_mreq,
    input  logic                n_iorq,
    input  logic                n_rd,
    input  logic                n_wr,
    output logic [7:0]          cpu_din,
    output logic                wait_n,
    input  logic [7:0]          rom_data,
    input  logic [7:0]          sram_din,
    output logic [PHYS_AW-1:0]  sram_addr,
    output logic                n_sram_cs,
    output logic                n_sram_oe,
    output logic                n_sram_we,
    output logic [NUM_IO-1:0]   n_io_cs,
    input  logic [8*NUM_IO-1:0] io_rd_data
);

    localparam int unsigned PW     = PHYS_AW - 14;
    localparam logic [8:0]  MAP_LO = {1'b0, MAP_PORT};
    localparam logic [8:0]  MAP_HI = MAP_LO + 9'd7;

    logic [PW-1:0]     r_page [4];
    logic              r_rom_en;
    logic              r_map_wr_q;

    logic              w_mem_acc, w_io_acc, w_idle;
    logic [8:0]        w_port;
    logic              w_map_hit, w_map_wr;
    logic [2:0]        w_map_off;
    logic              w_rom_sel, w_ram_sel;
    logic [NUM_IO-1:0] w_io_hit;
    logic [7:0]        w_map_rd_data;
    logic [7:0]        w_din;
    region_t           w_region;
    logic [WAIT_W-1:0] w_wait;
    logic              w_unused_dout;

    assign w_mem_acc = ~n_mreq & (~n_rd | ~n_wr);
    assign w_io_acc  = ~n_iorq & (~n_rd | ~n_wr);
    assign w_idle    = n_mreq & n_iorq & n_rd & n_wr;

    // 9-bit port compare keeps windows near 8'hFF from wrapping
    assign w_port    = {1'b0, cpu_addr[7:0]};
    assign w_map_hit = w_io_acc & (w_port >= MAP_LO) & (w_port <= MAP_HI);
    assign w_map_off = 3'(w_port - MAP_LO);
    assign w_map_wr  = w_map_hit & ~n_wr;

    assign w_rom_sel = r_rom_en & w_mem_acc & ((cpu_addr >> ROM_AW) == 16'd0);
    assign w_ram_sel = w_mem_acc & ~w_rom_sel;

    assign sram_addr = {r_page[cpu_addr[15:14]], cpu_addr[13:0]};
    assign n_sram_cs = ~w_ram_sel;
    assign n_sram_oe = n_sram_cs | n_rd;
    assign n_sram_we = n_sram_cs | n_wr;

    always_comb begin
        logic [8:0] v_lo;
        v_lo     = '0;
        w_io_hit = '0;
        for (int unsigned k = 0; k < NUM_IO; k++) begin
            v_lo = 9'(IO_BASE) + 9'(k << IO_SPAN);
            if (w_port >= v_lo && w_port <= v_lo + 9'((1 << IO_SPAN) - 1))
                w_io_hit[k] = 1'b1;
        end
    end

    assign n_io_cs = ~(w_io_hit & {NUM_IO{w_io_acc & ~w_map_hit}});

    // Mapper registers; r_map_wr_q makes a held n_wr write only once
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned k = 0; k < 4; k++)
                r_page[k] <= PW'(k);
            r_rom_en   <= 1'b1;
            r_map_wr_q <= 1'b0;
        end else begin
            r_map_wr_q <= w_map_wr;
            if (w_map_wr && !r_map_wr_q) begin
                case (w_map_off)
                    MAP_PAGE0, MAP_PAGE1, MAP_PAGE2, MAP_PAGE3:
                        r_page[w_map_off[1:0]] <= cpu_dout[PW-1:0];
                    MAP_ROMCTL:
                        r_rom_en <= ~cpu_dout[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_map_rd_data = 8'hFF;
        case (w_map_off)
            MAP_PAGE0, MAP_PAGE1, MAP_PAGE2, MAP_PAGE3:
                w_map_rd_data = 8'(r_page[w_map_off[1:0]]);
            MAP_ROMCTL:
                w_map_rd_data = {7'b0, ~r_rom_en};
            default: ;
        endcase
    end

    // Sources assigned lowest priority first so later ones override
    always_comb begin
        w_din = 8'hFF;
        if (w_ram_sel) w_din = sram_din;
        if (w_rom_sel) w_din = rom_data;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            if (!n_io_cs[NUM_IO-1-i])
                w_din = io_rd_data[8*(NUM_IO-1-i) +: 8];
        end
        if (w_map_hit && !n_rd) w_din = w_map_rd_data;
    end

    assign cpu_din = w_din;

    always_comb begin
        if (w_map_hit)      w_region = RGN_MAP;
        else if (w_io_acc)  w_region = RGN_IO;
        else if (w_rom_sel) w_region = RGN_ROM;
        else                w_region = RGN_RAM;
        case (w_region)
            RGN_ROM: w_wait = WAIT_W'(WAIT_ROM);
            RGN_RAM: w_wait = WAIT_W'(WAIT_RAM);
            RGN_IO:  w_wait = WAIT_W'(WAIT_IO);
            default: w_wait = '0;
        endcase
    end

    bus_wait_gen u_wait_gen (
        .clk      (clk),
        .n_reset  (n_reset),
        .i_access (w_mem_acc | w_io_acc),
        .i_idle   (w_idle),
        .i_wait   (w_wait),
        .o_wait_n (wait_n)
    );

    assign w_unused_dout = ^cpu_dout;

endmodule

// File: tb/tb_bus_controller.sv
module tb_bus_controller;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        n_mreq, n_iorq, n_rd, n_wr;
    logic [7:0]  cpu_din;
    logic        wait_n;
    logic [7:0]  rom_data;
    logic [7:0]  sram_din;
    logic [17:0] sram_addr;
    logic        n_sram_cs, n_sram_oe, n_sram_we;
    logic [3:0]  n_io_cs;
    logic [31:0] io_rd_data;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: page registers and ROM overlay enable
    int m_page [4];
    bit m_rom_en;

    always #5 clk = ~clk;

    bus_controller dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .n_mreq     (n_mreq),
        .n_iorq     (n_iorq),
        .n_rd       (n_rd),
        .n_wr       (n_wr),
        .cpu_din    (cpu_din),
        .wait_n     (wait_n),
        .rom_data   (rom_data),
        .sram_din   (sram_din),
        .sram_addr  (sram_addr),
        .n_sram_cs  (n_sram_cs),
        .n_sram_oe  (n_sram_oe),
        .n_sram_we  (n_sram_we),
        .n_io_cs    (n_io_cs),
        .io_rd_data (io_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_page[k] = k;
        m_rom_en = 1'b1;
    endtask

    task automatic strobes_off();
        n_mreq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    endtask

    function automatic int port_chan(input int p);
        if (p >= 'hF8) return -1;
        if (p >= 'h80 && p < 'hA0) return (p - 'h80) / 8;
        return -1;
    endfunction

    // One complete bus cycle with combinational and wait-length checks
    task automatic bus_op(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d);
        int port, ch, nw, lows, exp_din;
        bit map, rom;
        logic [3:0] ecs;
        bit ecs_sram;
        @(negedge clk);
        rom_data   = 8'($urandom);
        sram_din   = 8'($urandom);
        io_rd_data = $urandom;
        cpu_addr   = a;
        cpu_dout   = d;
        n_mreq = io; n_iorq = !io; n_rd = wr; n_wr = !wr;
        #1;
        port = int'(a[7:0]);
        map  = io && port >= 'hF8;
        ch   = io ? port_chan(port) : -1;
        rom  = !io && m_rom_en && int'(a) < 8192;
        ecs  = 4'hF;
        if (ch >= 0) ecs[ch] = 1'b0;
        ecs_sram = !(!io && !rom);
        chk("wait_idle", wait_n, 1'b1);
        chk("n_io_cs", n_io_cs, ecs);
        chk("n_sram_cs", n_sram_cs, ecs_sram);
        chk("n_sram_oe", n_sram_oe, ecs_sram | wr);
        chk("n_sram_we", n_sram_we, ecs_sram | !wr);
        if (!io) chk("sram_addr", sram_addr, m_page[a / 16384] * 16384 + (a % 16384));
        if (!wr) begin
            if (map) begin
                if (port - 'hF8 < 4)       exp_din = m_page[port - 'hF8];
                else if (port == 'hFC)     exp_din = m_rom_en ? 0 : 1;
                else                       exp_din = 'hFF;
            end else if (ch >= 0)          exp_din = (io_rd_data >> (8 * ch)) & 'hFF;
            else if (io)                   exp_din = 'hFF;
            else if (rom)                  exp_din = rom_data;
            else                           exp_din = sram_din;
            chk("cpu_din", cpu_din, exp_din);
        end
        nw = map ? 0 : io ? 2 : rom ? 0 : 1;
        lows = 0;
        for (int i = 0; i < nw + 3; i++) begin
            @(negedge clk);
            if (wait_n === 1'b0) lows++;
        end
        chk("wait_clocks", lows, nw);
        strobes_off();
        if (map && wr) begin
            if (port - 'hF8 < 4)   m_page[port - 'hF8] = d & 'hF;
            else if (port == 'hFC) m_rom_en = !d[0];
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        bit          rio, rwr;
        strobes_off();
        cpu_addr = '0; cpu_dout = '0; rom_data = '0; sram_din = '0; io_rd_data = '0;
        n_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_n_io_cs", n_io_cs, 4'hF);
        chk("rst_n_sram_cs", n_sram_cs, 1'b1);
        n_reset = 1'b1;
        @(negedge clk);

        // ROM read, page write, mapped RAM read, ROM disable, io channel read
        bus_op(1'b0, 1'b0, 16'h0100, 8'h00);
        bus_op(1'b1, 1'b1, 16'h00F9, 8'h05);
        bus_op(1'b0, 1'b0, 16'h4123, 8'h00);
        bus_op(1'b1, 1'b1, 16'h00FC, 8'h01);
        bus_op(1'b0, 1'b0, 16'h0010, 8'h00);
        bus_op(1'b1, 1'b0, 16'h00FC, 8'h00);
        bus_op(1'b1, 1'b0, 16'h0089, 8'h00);

        // Held mapper write: only the first data value may land in page 2
        @(negedge clk);
        cpu_addr = 16'h00FA; cpu_dout = 8'h0A;
        n_iorq = 1'b0; n_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cpu_dout = 8'(8'h03 + i);
        end
        strobes_off();
        m_page[2] = 'hA;
        @(negedge clk);
        bus_op(1'b1, 1'b0, 16'h00FA, 8'h00);

        // Ignored mapper ports, ROM re-enable, dropped ROM write, top channel
        bus_op(1'b1, 1'b1, 16'h00FD, 8'h01);
        bus_op(1'b1, 1'b0, 16'h00FD, 8'h00);
        bus_op(1'b1, 1'b1, 16'h00FC, 8'h00);
        bus_op(1'b0, 1'b1, 16'h0200, 8'h55);
        bus_op(1'b0, 1'b0, 16'h1FFF, 8'h00);
        bus_op(1'b0, 1'b0, 16'h2000, 8'h00);
        bus_op(1'b1, 1'b0, 16'h009F, 8'h00);
        bus_op(1'b1, 1'b0, 16'h00A0, 8'h00);

        for (int n = 0; n < 40; n++) begin
            rwr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: begin rio = 1'b0; ra = 16'($urandom_range(0, 16'h3FFF)); end
                1: begin rio = 1'b0; ra = 16'($urandom); end
                2: begin rio = 1'b1; ra = {8'($urandom), 8'($urandom_range(8'h80, 8'h9F))}; end
                3: begin rio = 1'b1; ra = {8'($urandom), 8'($urandom_range(8'hF8, 8'hFF))}; end
                default: begin rio = 1'b1; ra = 16'($urandom); end
            endcase
            bus_op(rio, rwr, ra, 8'($urandom));
        end

        // Reset in the middle of an io wait sequence
        bus_op(1'b1, 1'b1, 16'h00F8, 8'h07);
        bus_op(1'b1, 1'b1, 16'h00FB, 8'h09);
        bus_op(1'b1, 1'b1, 16'h00FC, 8'h01);
        @(negedge clk);
        cpu_addr = 16'h0081; n_iorq = 1'b0; n_rd = 1'b0;
        @(negedge clk);
        chk("count_wait_low", wait_n, 1'b0);
        n_reset = 1'b0;
        #1;
        chk("rst_abort_wait", wait_n, 1'b1);
        model_reset();
        strobes_off();
        n_mreq = 1'b0; n_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 16'(k * 16'h4000 + 16'h0123);
            #1;
            chk("rst_page", sram_addr, m_page[k] * 16384 + 'h123);
        end
        cpu_addr = 16'h0100; rom_data = 8'h3C;
        #1;
        chk("rst_rom_en", cpu_din, 8'h3C);
        @(negedge clk);
        strobes_off();
        n_reset = 1'b1;
        @(negedge clk);
        bus_op(1'b1, 1'b0, 16'h00FC, 8'h00);
        bus_op(1'b0, 1'b0, 16'hC001, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
